// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel enable in, counters/sync/blank/strobes/frame_count out (master = generator)
interface vga_timing_gen_if #(
  parameter int CW  = 10,
  parameter int FCW = 8
);
  logic           ce;
  logic [CW-1:0]  hcount;
  logic [CW-1:0]  vcount;
  logic           hsync;
  logic           vsync;
  logic           blank;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_count;
  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync, blank, line_start, frame_start, frame_count
  );
  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync, blank, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing (vclock, reset, bus: ce in; hcount/vcount/hsync/vsync/blank/line_start/frame_start/frame_count out)
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 31,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int FCW      = 8,
  parameter int DELAY    = 0
) (
  input  logic vclock,
  input  logic reset,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_A    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_S0   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_S1   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_A    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_S0   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_S1   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  localparam logic [4:0] SAFE = {1'b1, ~HS_ON, ~VS_ON, 2'b00};
  logic [CW-1:0]  h, v, hn, vn;
  logic [FCW-1:0] fc;
  logic           h_wrap, v_wrap;
  logic [4:0]     f, f_q, f_out;
  always_comb begin
    h_wrap = h == H_LAST;
    v_wrap = v == V_LAST;
    hn = h_wrap ? '0 : h + CW'(1);
    vn = h_wrap ? (v_wrap ? '0 : v + CW'(1)) : v;
    f = {(hn >= H_A) | (vn >= V_A),
         (hn >= H_S0 && hn < H_S1) ? HS_ON : ~HS_ON,
         (vn >= V_S0 && vn < V_S1) ? VS_ON : ~VS_ON,
         h_wrap,
         h_wrap & v_wrap};
  end
  always_ff @(posedge vclock) begin
    if (reset) begin
      h   <= '0;
      v   <= '0;
      fc  <= '0;
      f_q <= SAFE;
    end else begin
      f_q[1:0] <= 2'b00;
      if (bus.ce) begin
        h   <= hn;
        v   <= vn;
        fc  <= fc + FCW'(h_wrap & v_wrap);
        f_q <= f;
      end
    end
  end
  if (DELAY == 0) begin : g_nodly
    assign f_out = f_q;
  end else begin : g_dly
    logic [4:0] sr [DELAY];
    always_ff @(posedge vclock) begin
      if (reset) begin
        for (int i = 0; i < DELAY; i++) sr[i] <= SAFE;
      end else begin
        sr[0] <= f_q;
        for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
      end
    end
    assign f_out = sr[DELAY-1];
  end
  assign bus.hcount      = h;
  assign bus.vcount      = v;
  assign bus.frame_count = fc;
  assign {bus.blank, bus.hsync, bus.vsync, bus.line_start, bus.frame_start} = f_out;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for default and tiny (inverted polarity, DELAY=3) timing sets
module tb_vga_timing_gen;
  typedef struct {
    int         h, v, fc, ph;
    logic [4:0] f;
    bit         rst;
  } exp_t;
  logic vclock = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0, errors = 0, cyc = 0, ph = 0;
  exp_t q_a[$], q_b[$];
  always #5 vclock = ~vclock;
  vga_timing_gen_if #(.CW(10), .FCW(8)) bus_a ();
  vga_timing_gen_if #(.CW(3), .FCW(2)) bus_b ();
  vga_timing_gen u_a (.vclock(vclock), .reset(rst_a), .bus(bus_a.master));
  vga_timing_gen #(
    .CW(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .FCW(2), .DELAY(3)
  ) u_b (.vclock(vclock), .reset(rst_b), .bus(bus_b.master));
  int c_ha[2]  = '{640, 4};
  int c_hf[2]  = '{16, 1};
  int c_hsw[2] = '{96, 1};
  int c_hb[2]  = '{48, 1};
  int c_va[2]  = '{480, 3};
  int c_vf[2]  = '{11, 1};
  int c_vsw[2] = '{2, 1};
  int c_vb[2]  = '{31, 1};
  int c_pol[2] = '{0, 1};
  int c_dly[2] = '{0, 3};
  int c_fm[2]  = '{256, 4};
  int mh[2], mv[2], mfc[2];
  logic [4:0] live[2];
  logic [4:0] hist[2][16];
  task automatic model(input int i, input logic r, input logic c, output exp_t e);
    int ht, vt, hs0, vs0;
    logic p;
    logic [4:0] s;
    bit hw, vw;
    ht  = c_ha[i] + c_hf[i] + c_hsw[i] + c_hb[i];
    vt  = c_va[i] + c_vf[i] + c_vsw[i] + c_vb[i];
    hs0 = c_ha[i] + c_hf[i];
    vs0 = c_va[i] + c_vf[i];
    p   = c_pol[i][0];
    s   = {1'b1, ~p, ~p, 2'b00};
    if (r) begin
      mh[i] = 0; mv[i] = 0; mfc[i] = 0; live[i] = s;
      for (int k = 0; k < 16; k++) hist[i][k] = s;
    end else begin
      for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = live[i];
      live[i][1:0] = 2'b00;
      if (c) begin
        hw = mh[i] == ht - 1;
        vw = hw && mv[i] == vt - 1;
        mh[i] = hw ? 0 : mh[i] + 1;
        if (hw) mv[i] = vw ? 0 : mv[i] + 1;
        if (vw) mfc[i] = (mfc[i] + 1) % c_fm[i];
        live[i] = {mh[i] >= c_ha[i] || mv[i] >= c_va[i],
                   (mh[i] >= hs0 && mh[i] < hs0 + c_hsw[i]) ? p : ~p,
                   (mv[i] >= vs0 && mv[i] < vs0 + c_vsw[i]) ? p : ~p,
                   hw, vw};
      end
    end
    e.h = mh[i]; e.v = mv[i]; e.fc = mfc[i];
    e.f = c_dly[i] == 0 ? live[i] : hist[i][c_dly[i]-1];
  endtask
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask
  task automatic cmp(input string n, input exp_t e, input int h, input int v, input int fc, input logic [4:0] f);
    checks++;
    if (h != e.h || v != e.v || fc != e.fc || f !== e.f) begin
      errors++;
      $display("FAIL %s cyc=%0d: got h=%0d v=%0d fc=%0d {bl,hs,vs,ls,fs}=%b expected h=%0d v=%0d fc=%0d %b",
               n, cyc, h, v, fc, f, e.h, e.v, e.fc, e.f);
    end
  endtask
  task automatic step(input logic ra, input logic ca, input logic rb, input logic cb);
    exp_t ea, eb;
    rst_a = ra; bus_a.ce = ca; rst_b = rb; bus_b.ce = cb;
    @(posedge vclock);
    model(0, ra, ca, ea);
    model(1, rb, cb, eb);
    ea.rst = ra; ea.ph = ph; eb.rst = rb; eb.ph = ph;
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(negedge vclock);
  endtask
  int last_ph = -1, n_ls = 0, n_fs = 0, last_ls = 0, last_fs = 0, k_fs = 0;
  int t_bl = -1, t_hs = -1, prev_h = 0;
  logic prev_bl = 1'b1, prev_hs = 1'b0;
  always @(negedge vclock) begin
    exp_t ea, eb;
    cyc++;
    if (q_a.size() != 0 && q_b.size() != 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      cmp("a_cycle", ea, int'(bus_a.hcount), int'(bus_a.vcount), int'(bus_a.frame_count),
          {bus_a.blank, bus_a.hsync, bus_a.vsync, bus_a.line_start, bus_a.frame_start});
      cmp("b_cycle", eb, int'(bus_b.hcount), int'(bus_b.vcount), int'(bus_b.frame_count),
          {bus_b.blank, bus_b.hsync, bus_b.vsync, bus_b.line_start, bus_b.frame_start});
      if (eb.ph != last_ph) begin n_ls = 0; n_fs = 0; last_ph = eb.ph; end
      if (eb.rst) k_fs = 0;
      if (bus_a.line_start) begin
        if (n_ls >= 2 && eb.ph inside {1, 2}) chk("a_line_period", cyc - last_ls, 800 * eb.ph);
        n_ls++; last_ls = cyc;
      end
      if (bus_b.frame_start) begin
        if (n_fs >= 2 && eb.ph inside {1, 2}) chk("b_frame_period", cyc - last_fs, 42 * eb.ph);
        n_fs++; last_fs = cyc; k_fs++;
        chk("b_fc_at_frame_start", int'(bus_b.frame_count), k_fs % 4);
      end
      if (eb.ph inside {1, 2}) begin
        if (cyc == t_bl) chk("b_blank_rise_delay3", int'({prev_bl, bus_b.blank}), 1);
        if (cyc == t_hs) chk("b_hsync_rise_delay3", int'({prev_hs, bus_b.hsync}), 1);
        if (bus_b.hcount == 3'd4 && prev_h == 3 && bus_b.vcount < 3'd3) t_bl = cyc + 3;
        if (bus_b.hcount == 3'd5 && prev_h == 4) t_hs = cyc + 3;
      end
      prev_h  = int'(bus_b.hcount);
      prev_bl = bus_b.blank;
      prev_hs = bus_b.hsync;
    end
  end
  initial begin
    repeat (3) step(1, 1, 1, 1);
    chk("rst_a_hcount", int'(bus_a.hcount), 0);
    chk("rst_a_blank", int'(bus_a.blank), 1);
    chk("rst_a_hsync_inactive", int'(bus_a.hsync), 1);
    chk("rst_a_vsync_inactive", int'(bus_a.vsync), 1);
    chk("rst_b_hsync_inactive", int'(bus_b.hsync), 0);
    chk("rst_b_vsync_inactive", int'(bus_b.vsync), 0);
    chk("rst_b_blank", int'(bus_b.blank), 1);
    repeat (3) step(0, 0, 0, 0);
    chk("hold_a_blank_before_ce", int'(bus_a.blank), 1);
    chk("hold_a_hcount_before_ce", int'(bus_a.hcount), 0);
    step(0, 1, 0, 1);
    chk("first_ce_a_hcount", int'(bus_a.hcount), 1);
    chk("first_ce_a_blank", int'(bus_a.blank), 0);
    chk("first_ce_a_no_strobe", int'({bus_a.line_start, bus_a.frame_start}), 0);
    ph = 1;
    repeat (2500) step(0, 1, 0, 1);
    ph = 2;
    for (int k = 0; k < 5000; k++) step(0, k[0], 0, k[0]);
    ph = 3;
    for (int k = 0; k < 1000 && bus_a.hcount != 10'd300; k++) step(0, 1, 0, 1);
    chk("reach_a_h300", int'(bus_a.hcount), 300);
    step(1, 1, 1, 1);
    chk("midrst_a_hcount", int'(bus_a.hcount), 0);
    chk("midrst_a_vcount", int'(bus_a.vcount), 0);
    chk("midrst_a_fc", int'(bus_a.frame_count), 0);
    chk("midrst_a_blank", int'(bus_a.blank), 1);
    chk("midrst_a_hsync", int'(bus_a.hsync), 1);
    chk("midrst_b_fc", int'(bus_b.frame_count), 0);
    chk("midrst_b_syncs", int'({bus_b.hsync, bus_b.vsync}), 0);
    step(0, 1, 0, 1);
    chk("resume_a_hcount", int'(bus_a.hcount), 1);
    chk("resume_a_vcount", int'(bus_a.vcount), 0);
    ph = 4;
    for (int k = 0; k < 400; k++) begin
      logic c;
      c = 1'($urandom_range(0, 1));
      step(0, c, 0, c);
    end
    repeat (2) @(negedge vclock);
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
